// File: rtl/btn_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// btn_conditioner_pkg
//   Shared definitions for the pushbutton conditioning stage:
//   - per-channel debounce FSM state encoding
//   - default debounce constants for a 100 MHz system clock
//   - a small helper that decodes the debounced level from a state
// ---------------------------------------------------------------------------
package btn_conditioner_pkg;

    // Debounce FSM state encoding (2 bits, fixed values).
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } btn_state_t;

    // 20 ms of stability at 100 MHz.
    localparam int DEFAULT_STABLE_CYCLES = 2_000_000;
    localparam int DEFAULT_CNT_W         = 21;

    // The debounced level is "pressed" while the FSM sits in either of the
    // two states on the pressed side.
    function automatic logic state_is_pressed(input btn_state_t state);
        return (state == ST_PRESSED) || (state == ST_WAIT_RELEASE);
    endfunction

endpackage : btn_conditioner_pkg

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch
//   One pushbutton channel: two-flop synchroniser, stability counter and a
//   four-state debounce FSM.
//
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   i_btn_raw   in  raw asynchronous button level (1 = pressed)
//   o_level     out debounced level (decode of the state register)
//   o_press     out one-cycle pulse on an accepted 0->1 transition
//   o_release   out one-cycle pulse on an accepted 1->0 transition
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronised cycles a new value must hold (>= 2)
//   CNT_W          counter width, 2**CNT_W > STABLE_CYCLES-1
// ---------------------------------------------------------------------------
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    // Two-flop synchroniser; only r_sync feeds the FSM.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync  <= r_sync1;
        end
    end

    // Debounce FSM with registered press/release pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            r_press   <= 1'b0;
            r_release <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (r_sync) begin
                        r_state <= ST_WAIT_PRESS;
                        r_cnt   <= CNT_ONE;
                    end
                end

                ST_WAIT_PRESS: begin
                    if (!r_sync) begin
                        // Bounce: drop back without any output activity.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_PRESSED;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_PRESSED: begin
                    if (!r_sync) begin
                        r_state <= ST_WAIT_RELEASE;
                        r_cnt   <= CNT_ONE;
                    end
                end

                ST_WAIT_RELEASE: begin
                    if (r_sync) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_IDLE;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Level comes from the state register alone; no path from i_btn_raw.
    assign o_level   = state_is_pressed(r_state);
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   Conditions N raw pushbuttons for the graphics block: each channel is
//   synchronised and debounced independently.
//
// Ports:
//   clk          in  system clock (shared with the VGA path)
//   rst          in  asynchronous active-high reset
//   btn_raw      in  [N] raw button levels, 1 = pressed
//   btn_level    out [N] debounced level, 1 = pressed
//   btn_press    out [N] one-cycle pulse on accepted press
//   btn_release  out [N] one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_btn_raw (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g])
        );
    end

endmodule : btn_conditioner
